// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard (scan code set 2) receiver that reports the ASCII code of the held key.
// Optional shift handling is enabled by defining PS2_SHIFT_EN.
module ps2_key_decoder #(
   parameter logic [7:0]  IDLE_CODE      = 8'h31,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ascii,
   output logic [7:0] scan_code,
   output logic       key_valid
);

   logic [2:0]  r_clk_sync;
   logic [1:0]  r_dat_sync;
   logic [3:0]  r_bit_cnt;
   logic [10:0] r_shift;
   logic        r_frame_done;
   logic [19:0] r_to_cnt;
   logic        r_brk;
   logic        r_ext;
   logic        w_fall;
   logic        w_frame_ok;
   logic        w_shift;
   logic [7:0]  w_code;

   assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
   assign w_code     = r_shift[8:1];
   // r_shift[0] is the start bit, [9] parity, [10] stop once a frame has been collected
   assign w_frame_ok = r_frame_done & ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);

   function automatic logic [7:0] map_code(input logic [7:0] code, input logic shift);
      logic [7:0] c;
      c = 8'h00;
      case (code)
         8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
         8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
         8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
         8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
         8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
         8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
         8'h35: c = "y";  8'h1A: c = "z";
         8'h45: c = "0";  8'h16: c = "1";  8'h1E: c = "2";  8'h26: c = "3";
         8'h25: c = "4";  8'h2E: c = "5";  8'h36: c = "6";  8'h3D: c = "7";
         8'h3E: c = "8";  8'h46: c = "9";
         8'h5A: c = 8'h0D; 8'h29: c = 8'h20; 8'h76: c = 8'h1B; 8'h66: c = 8'h08;
         default: c = 8'h00;
      endcase
      if (shift) begin
         if (c >= "a" && c <= "z") c = c - 8'h20;
         case (code)
            8'h45: c = ")";  8'h16: c = "!";  8'h1E: c = "@";  8'h26: c = "#";
            8'h25: c = "$";  8'h2E: c = "%";  8'h36: c = "^";  8'h3D: c = "&";
            8'h3E: c = "*";  8'h46: c = "(";
            default: ;
         endcase
      end
      return c;
   endfunction

   // Synchronisers reset high so leaving reset never looks like a clock falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync <= 3'b111;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt    <= 4'd0;
         r_shift      <= 11'd0;
         r_frame_done <= 1'b0;
         r_to_cnt     <= 20'd0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_fall) begin
            r_to_cnt <= 20'd0;
            r_shift  <= {r_dat_sync[1], r_shift[10:1]};
            if (r_bit_cnt == 4'd10) begin
               r_bit_cnt    <= 4'd0;
               r_frame_done <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
         end else if (r_to_cnt == TIMEOUT_CYCLES) begin
            r_bit_cnt <= 4'd0;
         end else begin
            r_to_cnt <= r_to_cnt + 20'd1;
         end
      end
   end

`ifdef PS2_SHIFT_EN
   logic r_lshift;
   logic r_rshift;
   assign w_shift = r_lshift | r_rshift;
`else
   assign w_shift = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ascii     <= IDLE_CODE;
         scan_code <= 8'h00;
         key_valid <= 1'b0;
         r_brk     <= 1'b0;
         r_ext     <= 1'b0;
`ifdef PS2_SHIFT_EN
         r_lshift  <= 1'b0;
         r_rshift  <= 1'b0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (w_frame_ok) begin
            if (w_code == 8'hE0) begin
               r_ext <= 1'b1;
            end else if (w_code == 8'hF0) begin
               r_brk <= 1'b1;
`ifdef PS2_SHIFT_EN
            end else if (w_code == 8'h12 || w_code == 8'h59) begin
               if (w_code == 8'h12) r_lshift <= ~r_brk;
               else                 r_rshift <= ~r_brk;
               r_brk <= 1'b0;
               r_ext <= 1'b0;
`endif
            end else if (r_brk) begin
               // Only releasing the most recently pressed key returns to idle
               if (w_code == scan_code) ascii <= IDLE_CODE;
               r_brk <= 1'b0;
               r_ext <= 1'b0;
            end else begin
               scan_code <= w_code;
               ascii     <= r_ext ? 8'h00 : map_code(w_code, w_shift);
               key_valid <= 1'b1;
               r_ext     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder; covers the shift feature when PS2_SHIFT_EN is defined.
module tb_ps2_key_decoder;

   localparam logic [19:0] TB_TIMEOUT = 20'd3000;

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] ascii;
   logic [7:0] scan_code;
   logic       key_valid;

   int checks;
   int errors;
   int cyc;
   int kv_cnt;
   int kv_cyc;
   int stop_cyc;

   ps2_key_decoder #(.IDLE_CODE(8'h31), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ascii(ascii), .scan_code(scan_code), .key_valid(key_valid)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // pulse monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         kv_cnt = kv_cnt + 1;
         kv_cyc = cyc;
      end
   end

   // driver tasks
   task automatic send_bits(input logic [10:0] frame, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = frame[i];
         repeat (8) @(posedge clk);
         #1;
         ps2_clk  = 1'b0;
         stop_cyc = cyc;
         repeat (15) @(posedge clk);
         #1;
         ps2_clk = 1'b1;
         repeat (7) @(posedge clk);
         #1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_code(input logic [7:0] code);
      send_bits({1'b1, ~^code, code, 1'b0}, 11);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic send_bad_parity(input logic [7:0] code);
      send_bits({1'b1, ^code, code, 1'b0}, 11);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic send_bad_stop(input logic [7:0] code);
      send_bits({1'b0, ~^code, code, 1'b0}, 11);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (ascii !== 8'h31) begin errors++; $display("FAIL reset_ascii: got %h expected %h", ascii, 8'h31); end
      checks++;
      if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan: got %h expected %h", scan_code, 8'h00); end
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b expected 0", key_valid); end
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (kv_cnt !== 0) begin errors++; $display("FAIL idle_no_pulse: got %0d pulses expected 0", kv_cnt); end
   endtask

   task automatic test_make_break();
      int k0;
      k0 = kv_cnt;
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h61) begin errors++; $display("FAIL make_a_ascii: got %h expected %h", ascii, 8'h61); end
      checks++;
      if (scan_code !== 8'h1C) begin errors++; $display("FAIL make_a_scan: got %h expected %h", scan_code, 8'h1C); end
      checks++;
      if (kv_cnt - k0 !== 1) begin errors++; $display("FAIL make_a_pulse: got %0d pulses expected 1", kv_cnt - k0); end
      checks++;
      if (kv_cyc - stop_cyc < 1 || kv_cyc - stop_cyc > 6) begin
         errors++; $display("FAIL make_a_latency: got %0d cycles expected 1..6", kv_cyc - stop_cyc);
      end
      send_code(8'hF0);
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h31) begin errors++; $display("FAIL break_a_ascii: got %h expected %h", ascii, 8'h31); end
      checks++;
      if (kv_cnt - k0 !== 1) begin errors++; $display("FAIL break_no_pulse: got %0d pulses expected 1", kv_cnt - k0); end
   endtask

   task automatic test_back_to_back();
      int k0;
      send_code(8'h5A);
      checks++;
      if (ascii !== 8'h0D) begin errors++; $display("FAIL enter_ascii: got %h expected %h", ascii, 8'h0D); end
      k0 = kv_cnt;
      for (int i = 0; i < 3; i++) send_code(8'h5A);
      checks++;
      if (kv_cnt - k0 !== 3) begin errors++; $display("FAIL repeat_pulses: got %0d expected 3", kv_cnt - k0); end
      checks++;
      if (ascii !== 8'h0D) begin errors++; $display("FAIL repeat_ascii: got %h expected %h", ascii, 8'h0D); end
   endtask

   task automatic test_bad_frames();
      int k0;
      k0 = kv_cnt;
      send_bad_parity(8'h1C);
      checks++;
      if (ascii !== 8'h0D || scan_code !== 8'h5A) begin
         errors++; $display("FAIL bad_parity: got %h/%h expected 0d/5a", ascii, scan_code);
      end
      send_bad_stop(8'h1C);
      checks++;
      if (ascii !== 8'h0D || scan_code !== 8'h5A) begin
         errors++; $display("FAIL bad_stop: got %h/%h expected 0d/5a", ascii, scan_code);
      end
      checks++;
      if (kv_cnt - k0 !== 0) begin errors++; $display("FAIL bad_no_pulse: got %0d expected 0", kv_cnt - k0); end
      send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 5);
      repeat (int'(TB_TIMEOUT) + 50) @(posedge clk);
      #1;
      send_code(8'h32);
      checks++;
      if (ascii !== 8'h62) begin errors++; $display("FAIL timeout_ascii: got %h expected %h", ascii, 8'h62); end
      checks++;
      if (scan_code !== 8'h32) begin errors++; $display("FAIL timeout_scan: got %h expected %h", scan_code, 8'h32); end
   endtask

   task automatic test_overlap();
      send_code(8'h1C);
      send_code(8'h32);
      send_code(8'hF0);
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h62) begin errors++; $display("FAIL overlap_old_release: got %h expected %h", ascii, 8'h62); end
      send_code(8'hF0);
      send_code(8'h32);
      checks++;
      if (ascii !== 8'h31) begin errors++; $display("FAIL overlap_new_release: got %h expected %h", ascii, 8'h31); end
   endtask

   task automatic test_extended();
      int k0;
      k0 = kv_cnt;
      send_code(8'hE0);
      send_code(8'h75);
      checks++;
      if (ascii !== 8'h00 || scan_code !== 8'h75) begin
         errors++; $display("FAIL ext_make: got %h/%h expected 00/75", ascii, scan_code);
      end
      checks++;
      if (kv_cnt - k0 !== 1) begin errors++; $display("FAIL ext_pulse: got %0d expected 1", kv_cnt - k0); end
      send_code(8'hE0);
      send_code(8'hF0);
      send_code(8'h75);
      checks++;
      if (ascii !== 8'h31) begin errors++; $display("FAIL ext_break: got %h expected %h", ascii, 8'h31); end
      // extended flag must not leak into the next ordinary make
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h61) begin errors++; $display("FAIL ext_cleared: got %h expected %h", ascii, 8'h61); end
   endtask

   task automatic test_map();
      logic [7:0] codes [8];
      logic [7:0] exps  [8];
      codes = '{8'h16, 8'h45, 8'h46, 8'h29, 8'h76, 8'h66, 8'h1A, 8'h0E};
      exps  = '{8'h31, 8'h30, 8'h39, 8'h20, 8'h1B, 8'h08, 8'h7A, 8'h00};
      for (int i = 0; i < 8; i++) begin
         send_code(codes[i]);
         checks++;
         if (ascii !== exps[i] || scan_code !== codes[i]) begin
            errors++; $display("FAIL map_%h: got %h/%h expected %h/%h", codes[i], ascii, scan_code, exps[i], codes[i]);
         end
      end
   endtask

   task automatic test_shift();
`ifdef PS2_SHIFT_EN
      send_code(8'h12);
      checks++;
      if (scan_code !== 8'h0E) begin errors++; $display("FAIL shift_keeps_scan: got %h expected %h", scan_code, 8'h0E); end
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h41) begin errors++; $display("FAIL shift_upper: got %h expected %h", ascii, 8'h41); end
      send_code(8'hF0);
      send_code(8'h12);
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h61) begin errors++; $display("FAIL shift_release: got %h expected %h", ascii, 8'h61); end
      send_code(8'h59);
      send_code(8'h16);
      checks++;
      if (ascii !== 8'h21) begin errors++; $display("FAIL rshift_digit: got %h expected %h", ascii, 8'h21); end
      send_code(8'hF0);
      send_code(8'h59);
`else
      send_code(8'h12);
      checks++;
      if (ascii !== 8'h00 || scan_code !== 8'h12) begin
         errors++; $display("FAIL noshift_12: got %h/%h expected 00/12", ascii, scan_code);
      end
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h61) begin errors++; $display("FAIL noshift_lower: got %h expected %h", ascii, 8'h61); end
`endif
   endtask

   task automatic test_reset_mid_frame();
      send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ascii !== 8'h31 || scan_code !== 8'h00 || key_valid !== 1'b0) begin
         errors++; $display("FAIL midframe_reset: got %h/%h/%b expected 31/00/0", ascii, scan_code, key_valid);
      end
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      send_code(8'h1C);
      checks++;
      if (ascii !== 8'h61 || scan_code !== 8'h1C) begin
         errors++; $display("FAIL midframe_recover: got %h/%h expected 61/1c", ascii, scan_code);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      kv_cnt   = 0;
      kv_cyc   = 0;
      stop_cyc = 0;
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      test_reset();
      test_make_break();
      test_back_to_back();
      test_bad_frames();
      test_overlap();
      test_extended();
      test_map();
      test_shift();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
